// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end.
//   CPU_PCW    : default program-counter / instruction-address width
//   CPU_IW     : default instruction word width
//   fq_entry_t : one fetch-queue slot {pc, inst, filled}
// The entry struct uses the package widths; modules whose PCW/IW parameters
// are narrower zero-extend into it.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_PCW = 32;
  localparam int CPU_IW  = 32;

  typedef struct packed {
    logic [CPU_PCW-1:0] pc;
    logic [CPU_IW-1:0]  inst;
    logic               filled;
  } fq_entry_t;

endpackage

// File: rtl/fq_credit_ctr.sv
// ---------------------------------------------------------------------------
// fq_credit_ctr
// Request/response accounting for the fetch queue. It tracks every issued
// request that has not been answered yet (outstanding), including requests
// whose data must be thrown away after a flush (drop_cnt). A doomed response
// still occupies a queue credit until it comes back, so live counts both the
// allocated buffer entries and the pending drops.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : branch redirect this cycle
//   issue_fire   : a read request is accepted this cycle
//   resp_valid   : a read response arrives this cycle
//   alloc_cnt    : entries currently allocated in the buffer
//   drop_resp    : the response arriving this cycle must be discarded
//   live         : alloc_cnt + drop_cnt, the number of credits in use
// ---------------------------------------------------------------------------
module fq_credit_ctr
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          issue_fire,
  input  logic          resp_valid,
  input  logic [CW-1:0] alloc_cnt,
  output logic          drop_resp,
  output logic [CW-1:0] live
);

  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt_next;
  logic          has_drop;

  assign has_drop  = (drop_cnt != '0);
  assign drop_resp = resp_valid & (has_drop | flush);
  assign live      = alloc_cnt + drop_cnt;

  // On a flush every request still in flight becomes a drop, except the one
  // answered in this very cycle (it is discarded immediately). Deriving the
  // count from outstanding keeps back-to-back flushes exact.
  always_comb begin
    outstanding_next = outstanding + CW'(issue_fire) - CW'(resp_valid);
    drop_cnt_next    = drop_cnt;
    if (flush)
      drop_cnt_next = outstanding - CW'(resp_valid);
    else if (resp_valid && has_drop)
      drop_cnt_next = drop_cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction fetch buffer between the program counter, instruction memory
// and decode. The current PC is issued as a memory read whenever a credit is
// free. Returned words are stored in order, and the head is presented to
// decode as {pc, inst} with valid/ready. A flush (branch redirect) empties
// the buffer and arranges for every response still in flight to be dropped.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   pc_in             : current PC from the program counter
//   halt              : suppress new fetches
//   flush             : branch redirect, PC loads its target this cycle
//   stall             : PC must hold this cycle
//   imem_req_valid/_ready, imem_addr      : read request channel
//   imem_resp_valid, imem_resp_data       : in-order read responses
//   out_valid/_ready, out_pc, out_inst    : instruction stream to decode
// PCW/IW must not exceed the cpu_pkg widths used by the entry struct.
// ---------------------------------------------------------------------------
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int PCW   = CPU_PCW,
  parameter int IW    = CPU_IW,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [PCW-1:0] pc_in,
  input  logic           halt,
  input  logic           flush,
  output logic           stall,
  output logic           imem_req_valid,
  input  logic           imem_req_ready,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_resp_valid,
  input  logic [IW-1:0]  imem_resp_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PCW-1:0] out_pc,
  output logic [IW-1:0]  out_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Pointers carry one extra bit so that wr_ptr - rd_ptr distinguishes a
  // full buffer from an empty one; the low AW bits index the slots.
  logic [CW-1:0] wr_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0] alloc_cnt, live;
  logic [AW-1:0] wr_idx, fill_idx, rd_idx;

  fq_entry_t entries [DEPTH];
  fq_entry_t head;

  logic can_issue, issue_fire, drop_resp, fill_en, pop;

  assign alloc_cnt = wr_ptr - rd_ptr;
  assign wr_idx    = wr_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign head      = entries[rd_idx];

  fq_credit_ctr #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .issue_fire (issue_fire),
    .resp_valid (imem_resp_valid),
    .alloc_cnt  (alloc_cnt),
    .drop_resp  (drop_resp),
    .live       (live)
  );

  // Credit check uses registered state only, so a pop in the same cycle
  // frees its credit one cycle later. Outputs are forced low while reset is
  // asserted so the PC and memory see a quiet interface immediately.
  assign can_issue      = (live < FULL_CNT) & ~halt & ~flush;
  assign imem_req_valid = rst_n & can_issue;
  assign imem_addr      = pc_in;
  assign issue_fire     = imem_req_valid & imem_req_ready;

  // During halt the PC holds itself, so stall is only raised for a
  // request that could not be issued.
  assign stall = rst_n & ~halt & ~issue_fire;

  // drop_resp already covers a response coinciding with a flush.
  assign fill_en = imem_resp_valid & ~drop_resp;

  assign out_valid = rst_n & head.filled & ~flush;
  assign out_pc    = PCW'(head.pc);
  assign out_inst  = IW'(head.inst);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else begin
      if (issue_fire) wr_ptr   <= wr_ptr + CW'(1);
      if (fill_en)    fill_ptr <= fill_ptr + CW'(1);
      if (pop)        rd_ptr   <= rd_ptr + CW'(1);
    end
  end

  // Allocation, fill and pop touch different slots in the same cycle:
  // allocation only happens when not full and pop only when the head is
  // filled, which the fill slot never is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
    end else begin
      if (issue_fire) begin
        entries[wr_idx].pc     <= CPU_PCW'(pc_in);
        entries[wr_idx].filled <= 1'b0;
      end
      if (fill_en) begin
        entries[fill_idx].inst   <= CPU_IW'(imem_resp_data);
        entries[fill_idx].filled <= 1'b1;
      end
      if (pop) entries[rd_idx].filled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue. The bench plays the program counter
// (pc_in advances by 4 on every accepted request) and a fixed-latency,
// in-order instruction memory whose data is a simple function of the
// address. Expected values below are worked out cycle by cycle by hand.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int PCW   = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [PCW-1:0] pc_in = '0;
  logic           halt = 1'b0;
  logic           flush = 1'b0;
  logic           stall;
  logic           imem_req_valid;
  logic           imem_req_ready = 1'b1;
  logic [PCW-1:0] imem_addr;
  logic           imem_resp_valid = 1'b0;
  logic [IW-1:0]  imem_resp_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [PCW-1:0] out_pc;
  logic [IW-1:0]  out_inst;

  int tests = 0;
  int fails = 0;
  int lat = 1;

  logic           pv [8];
  logic [PCW-1:0] pa [8];

  fetch_queue #(.PCW(PCW), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_in           (pc_in),
    .halt            (halt),
    .flush           (flush),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] instOf(input logic [PCW-1:0] a);
    return (a * 3) ^ 32'hA5A5_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expectOut(input string tag, input logic v, input logic [PCW-1:0] p);
    checkOutput({tag, ".valid"}, out_valid, v);
    if (v) begin
      checkOutput({tag, ".pc"}, out_pc, p);
      checkOutput({tag, ".inst"}, out_inst, instOf(p));
    end
  endtask

  // Drive the cycle's inputs just after the clock edge, then move to the
  // falling edge where outputs are settled and can be checked.
  task automatic applyStimulus(input logic h, input logic f, input logic ordy);
    halt      = h;
    flush     = f;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Close the cycle: note whether a request fired, cross the rising edge,
  // then advance the PC and the memory latency pipeline.
  task automatic tick();
    logic           fire;
    logic [PCW-1:0] addr;
    fire = imem_req_valid & imem_req_ready;
    addr = imem_addr;
    @(posedge clk);
    #1;
    if (fire) pc_in = pc_in + 32'd4;
    for (int i = 7; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = fire;
    pa[0] = addr;
    imem_resp_valid = pv[lat-1];
    imem_resp_data  = instOf(pa[lat-1]);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
  endtask

  task automatic doReset(input int l);
    rst_n = 1'b0;
    lat = l;
    clearMem();
    halt = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    pc_in = '0;
    @(negedge clk);
    checkOutput("reset.out_valid", out_valid, 0);
    checkOutput("reset.req_valid", imem_req_valid, 0);
    checkOutput("reset.stall", stall, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clearMem();

    // Streaming at latency 1: first output two cycles after first request.
    doReset(1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("stream.stall%0d", k), stall, 0);
      expectOut($sformatf("stream.c%0d", k), (k >= 2), 32'((k - 2) * 4));
      tick();
    end

    // Backpressure until full, then drain one per cycle with wrap-around.
    doReset(1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("full.stall%0d", k), stall, (k >= 4));
      checkOutput($sformatf("full.req%0d", k), imem_req_valid, (k < 4));
      checkOutput($sformatf("full.addr%0d", k), imem_addr, (k < 4) ? 32'(k * 4) : 32'd16);
      if (k >= 2) expectOut($sformatf("full.c%0d", k), 1, 32'd0);
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("drain.stall%0d", j), stall, (j == 0));
      expectOut($sformatf("drain.c%0d", j), 1, 32'(j * 4));
      tick();
    end

    // Flush with three requests in flight at latency 4, redirect to 0x100.
    doReset(4);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("fl3.req%0d", k), imem_req_valid, 1);
      tick();
    end
    applyStimulus(0, 1, 1);
    checkOutput("fl3.flush_req", imem_req_valid, 0);
    checkOutput("fl3.flush_stall", stall, 1);
    tick();
    pc_in = 32'h100;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("fl3.stall%0d", k), stall, (k == 4));
      expectOut($sformatf("fl3.c%0d", k), 0, 32'd0);
      tick();
    end
    applyStimulus(0, 0, 1);
    expectOut("fl3.first", 1, 32'h100);
    tick();
    applyStimulus(0, 0, 1);
    expectOut("fl3.second", 1, 32'h104);
    tick();

    // Flush coinciding with a response and with out_valid high.
    doReset(2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1);
      tick();
    end
    applyStimulus(0, 1, 1);
    checkOutput("flr.flush_out_valid", out_valid, 0);
    tick();
    pc_in = 32'h200;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("flr.stall%0d", k), stall, 0);
      expectOut($sformatf("flr.c%0d", k), 0, 32'd0);
      tick();
    end
    applyStimulus(0, 0, 1);
    expectOut("flr.first", 1, 32'h200);
    tick();
    applyStimulus(0, 0, 1);
    expectOut("flr.second", 1, 32'h204);
    tick();

    // Halt: no requests, no stall, buffered entries still drain.
    doReset(1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 0);
      tick();
    end
    applyStimulus(1, 0, 0);
    checkOutput("halt.req", imem_req_valid, 0);
    checkOutput("halt.stall", stall, 0);
    expectOut("halt.c2", 1, 32'd0);
    tick();
    applyStimulus(1, 0, 1);
    expectOut("halt.c3", 1, 32'd0);
    tick();
    applyStimulus(1, 0, 1);
    expectOut("halt.c4", 1, 32'd4);
    tick();
    applyStimulus(1, 0, 1);
    expectOut("halt.c5", 0, 32'd0);
    checkOutput("halt.c5.req", imem_req_valid, 0);
    checkOutput("halt.c5.stall", stall, 0);
    tick();
    applyStimulus(0, 0, 1);
    checkOutput("resume.req", imem_req_valid, 1);
    checkOutput("resume.addr", imem_addr, 32'd8);
    checkOutput("resume.stall", stall, 0);
    tick();
    applyStimulus(0, 0, 1);
    checkOutput("resume.addr2", imem_addr, 32'd12);
    tick();
    applyStimulus(0, 0, 1);
    expectOut("resume.out", 1, 32'd8);
    tick();

    // Asynchronous reset in the middle of a burst.
    doReset(1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 1);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset.out_valid", out_valid, 0);
    checkOutput("areset.req_valid", imem_req_valid, 0);
    checkOutput("areset.stall", stall, 0);
    clearMem();
    pc_in = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 1);
    checkOutput("areset.addr", imem_addr, 32'd0);
    checkOutput("areset.req", imem_req_valid, 1);
    tick();
    applyStimulus(0, 0, 1);
    expectOut("areset.c1", 0, 32'd0);
    tick();
    applyStimulus(0, 0, 1);
    expectOut("areset.c2", 1, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
